counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
- Sequencing controller for an 8-bit up-counter datapath.
- Accepts start/stop/pause commands, latches a terminal count and runs the counter from 0 up to that value.
- Signals completion, and optionally auto-reloads for periodic operation.
- Sits between control logic (CPU/FSM) and any block needing a programmable interval or tick.

Parameters:
- WIDTH, 8, bit width of count and terminal count.
- PWIDTH, 8, bit width of completed-period counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  start command, sampled each rising edge.
- stop  input  1  abort command, sampled each rising edge.
- pause  input  1  level; holds count while high.
- auto_reload  input  1  level; sampled in DONE to choose restart vs idle.
- term_cnt  input  WIDTH  terminal count, latched on accepted start.
- count  output  WIDTH  current count value.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse, high exactly while in DONE.
- aborted  output  1  one-cycle pulse after a stop is accepted.
- err  output  1  one-cycle pulse after a start with term_cnt==0.
- periods  output  PWIDTH  completed-period count, saturates at all-ones.

Behaviour:
- One clock; reset is asynchronous and active-high. Port names are clk and reset.
- Reset: state=IDLE; count=0, tc_q=0, periods=0; busy=done=aborted=err=0.
- All outputs are registered or decoded from the state register only. No input-to-output combinational paths.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority each edge: stop > start > pause.
- IDLE:
  - count holds its last value.
  - start with term_cnt!=0: tc_q<=term_cnt, count<=0, periods<=0, go to RUN.
  - start with term_cnt==0: err=1 next cycle, stay IDLE, count unchanged.
  - stop in IDLE: ignored, no aborted pulse.
- RUN:
  - pause=1: go to PAUSE, count holds.
  - Otherwise count<=count+1.
  - If count==tc_q-1, count<=tc_q and go to DONE.
- PAUSE:
  - count holds.
  - pause=0: go to RUN. The leaving edge does not increment; counting resumes on the following edge.
- DONE (exactly one cycle):
  - done=1, count=tc_q, periods<=periods+1 (saturating).
  - auto_reload=1: count<=0, go to RUN; tc_q is reused, term_cnt is not re-sampled.
  - Otherwise go to IDLE; count holds tc_q.
- stop in RUN, PAUSE or DONE: go to IDLE next edge, count holds, aborted=1 for one cycle.
  - No done pulse on the exit edge.
  - periods is not incremented when stop coincides with DONE.
- start while busy: ignored. No restart and no tc_q update.
- term_cnt changes while busy: ignored.
- Latency: start accepted at edge E0 → count=k after edge Ek → count=tc and done=1 after edge E(tc).
  - One-shot run lasts tc cycles in RUN plus 1 cycle in DONE.
  - Auto-reload period is tc+1 cycles, with done spaced tc+1 cycles apart.
- tc=all-ones (255): count reaches 255 and never wraps past tc_q.
- tc=1: RUN lasts one cycle (0→1), then DONE.
- Reset asserted mid-operation: immediate return to reset values, independent of clk.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
  - default widths.
- One sub-module, interval_counter: WIDTH-bit register with synchronous clr (priority) and en. counter_ctrl drives clr/en from its FSM.
- The saturating periods counter stays inline.

Test Plan:
1. reset high for 3 cycles, then low → count=0, busy=0, periods=0. Reassert reset mid-RUN at count=4 → count=0 and IDLE with no clock edge.
2. start with term_cnt=5, auto_reload=0 → count 1..5 on the next 5 edges, done=1 for exactly one cycle when count=5, then IDLE with busy=0, count=5, periods=1.
3. term_cnt=3, auto_reload=1, start, run 3 periods → done pulses 4 cycles apart, count sequence 0,1,2,3,0,1,2,3…, periods=3.
4. term_cnt=10, start, assert pause at count=4 for 3 cycles → count holds at 4, then resumes. done occurs 4 cycles later than in an unpaused run.
5. term_cnt=8, start, assert stop at count=6 → aborted=1 for one cycle, IDLE, count=6, no done. Then start with term_cnt=0 → err=1 for one cycle, busy stays 0.
6. Assert start again at count=2 with term_cnt=9 (initial tc=4), and assert stop+start together on the same edge → no restart, tc stays 4. stop wins: IDLE, aborted=1.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding and default widths
// for the counter_ctrl sequencing block.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_PWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl_interval_counter.sv
// Up-counter register with synchronous clear
// (wins over enable) and count enable.
module interval_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/pause sequencer driving an interval
// counter up to a latched terminal count.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              auto_reload,
  input  logic [WIDTH-1:0]  term_cnt,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [PWIDTH-1:0] periods
);

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] tc_q;
  logic cnt_clr;
  logic cnt_en;
  logic tc_ld;
  logic per_clr;
  logic per_inc;
  logic abort_d;
  logic err_d;
  logic last;

  // tc_q is never zero while busy, so tc_q-1 cannot underflow
  assign last = (count == tc_q - 1'b1);

  interval_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  always_comb begin
    nxt     = state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    tc_ld   = 1'b0;
    per_clr = 1'b0;
    per_inc = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!stop && start) begin
          if (term_cnt != '0) begin
            tc_ld   = 1'b1;
            cnt_clr = 1'b1;
            per_clr = 1'b1;
            nxt     = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          abort_d = 1'b1;
          nxt     = ST_IDLE;
        end else if (pause) begin
          nxt = ST_PAUSE;
        end else begin
          cnt_en = 1'b1;
          if (last) begin
            nxt = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          abort_d = 1'b1;
          nxt     = ST_IDLE;
        end else if (!pause) begin
          nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) begin
          abort_d = 1'b1;
          nxt     = ST_IDLE;
        end else begin
          per_inc = 1'b1;
          if (auto_reload) begin
            cnt_clr = 1'b1;
            nxt     = ST_RUN;
          end else begin
            nxt = ST_IDLE;
          end
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tc_q    <= '0;
      periods <= '0;
      aborted <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= nxt;
      aborted <= abort_d;
      err     <= err_d;
      if (tc_ld) begin
        tc_q <= term_cnt;
      end
      if (per_clr) begin
        periods <= '0;
      end else if (per_inc && (periods != '1)) begin
        periods <= periods + 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized and directed bench for counter_ctrl
// against a behavioural model of the sequencer.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic [7:0] term_cnt;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       err;
  logic [7:0] periods;

  int vectors = 0;
  int miscompares = 0;

  // model: 0 idle, 1 counting, 2 held, 3 finished
  int m_phase, m_count, m_tc, m_periods;
  bit m_ab, m_err;

  counter_ctrl #(.WIDTH(8), .PWIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .term_cnt    (term_cnt),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .err         (err),
    .periods     (periods)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] dut_v();
    return {count, busy, done, aborted, err, periods};
  endfunction

  function automatic logic [19:0] mdl_v();
    logic [7:0] c;
    logic [7:0] p;
    c = m_count[7:0];
    p = m_periods[7:0];
    return {c, m_phase != 0, m_phase == 3, m_ab, m_err, p};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_tc = 0;
    m_periods = 0; m_ab = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ab, er;
    ab = 0; er = 0;
    if (stop && m_phase != 0) begin
      m_phase = 0;
      ab = 1;
    end else begin
      case (m_phase)
        0: if (start && !stop) begin
          if (term_cnt != 0) begin
            m_tc = term_cnt; m_count = 0;
            m_periods = 0; m_phase = 1;
          end else begin
            er = 1;
          end
        end
        1: if (pause) m_phase = 2;
           else begin
             m_count = m_count + 1;
             if (m_count == m_tc) m_phase = 3;
           end
        2: if (!pause) m_phase = 1;
        default: begin
          if (m_periods < 255) m_periods++;
          if (auto_reload) begin
            m_count = 0; m_phase = 1;
          end else m_phase = 0;
        end
      endcase
    end
    m_ab = ab; m_err = er;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic idle_in();
    start = 0; stop = 0; pause = 0;
    auto_reload = 0; term_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset = 0;
    vectors++;
    if (dut_v() !== 20'h0) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", dut_v(), 20'h0);
    end
  endtask

  task automatic test_oneshot();
    term_cnt = 5; start = 1;
    tick();
    start = 0;
    vectors++;
    if (count !== 0 || busy !== 1) begin
      miscompares++;
      $display("FAIL os_start: got c=%0d b=%b want 0 1", count, busy);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (count !== k[7:0] || done !== (k == 5) || dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL os_run%0d: got %h want %h", k, dut_v(), mdl_v());
      end
    end
    tick();
    vectors++;
    if (busy !== 0 || count !== 5 || periods !== 1 || done !== 0) begin
      miscompares++;
      $display("FAIL os_end: got %h want c=5 p=1 idle", dut_v());
    end
  endtask

  task automatic test_autoreload();
    int ndone, lastd;
    ndone = 0; lastd = -1;
    term_cnt = 3; auto_reload = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (dut_v() !== mdl_v() || count !== ((i + 1) % 4)) begin
        miscompares++;
        $display("FAIL ar_cyc%0d: got %h want %h", i, dut_v(), mdl_v());
      end
      if (done) begin
        if (lastd >= 0) begin
          vectors++;
          if (i - lastd != 4) begin
            miscompares++;
            $display("FAIL ar_space: got %0d want 4", i - lastd);
          end
        end
        lastd = i;
        ndone++;
      end
    end
    vectors++;
    if (ndone != 3 || periods !== 3) begin
      miscompares++;
      $display("FAIL ar_per: got d=%0d p=%0d want 3 3", ndone, periods);
    end
    auto_reload = 0; stop = 1;
    tick();
    stop = 0;
    vectors++;
    if (aborted !== 1 || busy !== 0 || dut_v() !== mdl_v()) begin
      miscompares++;
      $display("FAIL ar_stop: got %h want %h", dut_v(), mdl_v());
    end
  endtask

  task automatic test_pause();
    int n;
    term_cnt = 10; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (count !== 4 || busy !== 1) begin
        miscompares++;
        $display("FAIL ps_hold: got c=%0d want 4", count);
      end
    end
    pause = 0;
    n = 7;
    while (!done && n < 40) begin
      tick();
      n++;
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL ps_run: got %h want %h", dut_v(), mdl_v());
      end
    end
    vectors++;
    if (n != 14 || count !== 10) begin
      miscompares++;
      $display("FAIL ps_done: got edge %0d c=%0d want 14 10", n, count);
    end
    tick();
  endtask

  task automatic test_stop_err();
    term_cnt = 8; start = 1;
    tick();
    start = 0;
    repeat (6) tick();
    stop = 1;
    tick();
    stop = 0;
    vectors++;
    if (aborted !== 1 || busy !== 0 || count !== 6 || done !== 0) begin
      miscompares++;
      $display("FAIL st_abort: got %h want c=6 ab=1", dut_v());
    end
    tick();
    vectors++;
    if (aborted !== 0) begin
      miscompares++;
      $display("FAIL st_pulse: got %b want 0", aborted);
    end
    term_cnt = 0; start = 1;
    tick();
    start = 0;
    vectors++;
    if (err !== 1 || busy !== 0 || count !== 6) begin
      miscompares++;
      $display("FAIL er_set: got %h want err=1 c=6", dut_v());
    end
    tick();
    vectors++;
    if (err !== 0 || busy !== 0) begin
      miscompares++;
      $display("FAIL er_pulse: got e=%b b=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_back_to_back();
    term_cnt = 4; start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    term_cnt = 9; start = 1;
    tick();
    start = 0;
    tick();
    vectors++;
    if (count !== 4 || done !== 1) begin
      miscompares++;
      $display("FAIL bb_tc: got c=%0d d=%b want 4 1", count, done);
    end
    stop = 1; start = 1;
    tick();
    stop = 0; start = 0;
    vectors++;
    if (aborted !== 1 || busy !== 0 || periods !== 0 || count !== 4) begin
      miscompares++;
      $display("FAIL bb_dstop: got %h want %h", dut_v(), mdl_v());
    end
    term_cnt = 4; start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    stop = 1; start = 1; term_cnt = 9;
    tick();
    stop = 0; start = 0;
    vectors++;
    if (aborted !== 1 || busy !== 0 || count !== 2 || dut_v() !== mdl_v()) begin
      miscompares++;
      $display("FAIL bb_ss: got %h want %h", dut_v(), mdl_v());
    end
  endtask

  task automatic test_boundaries();
    term_cnt = 1; start = 1;
    tick();
    start = 0;
    tick();
    vectors++;
    if (count !== 1 || done !== 1) begin
      miscompares++;
      $display("FAIL tc1: got c=%0d d=%b want 1 1", count, done);
    end
    tick();
    term_cnt = 255; start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      vectors++;
      if (done !== (k == 255) || dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL tc255_%0d: got %h want %h", k, dut_v(), mdl_v());
      end
    end
    tick();
    vectors++;
    if (count !== 255 || busy !== 0 || periods !== 1) begin
      miscompares++;
      $display("FAIL tc255_end: got %h want c=255 idle", dut_v());
    end
  endtask

  task automatic test_reset_mid();
    term_cnt = 10; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    #2;
    reset = 1;
    #1;
    model_reset();
    vectors++;
    if (count !== 0 || busy !== 0 || periods !== 0) begin
      miscompares++;
      $display("FAIL rst_mid: got %h want 0", dut_v());
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      start = ($urandom % 6) == 0;
      stop = ($urandom % 20) == 0;
      if (m_phase == 0) stop = 0;
      pause = ($urandom % 5) == 0;
      auto_reload = $urandom % 2;
      term_cnt = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom % 12);
      tick();
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL rnd%0d: got %h want %h", i, dut_v(), mdl_v());
      end
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause();
    test_stop_err();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
